// File: rtl/pc_unit_ras.sv
// Program counter with four-way next-PC select, stall hold, sticky
// misaligned-fetch trap and a circular return-address stack.
module pc_unit_ras #(
  parameter int ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int RAS_DEPTH = 4,
  parameter int IMM_SHIFT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall,
  input  logic [1:0]               PCsrc,
  input  logic [ADDRESS_WIDTH-1:0] ImmOp,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic                     push,
  output logic [ADDRESS_WIDTH-1:0] PC,
  output logic [ADDRESS_WIDTH-1:0] inc_PC,
  output logic                     trap,
  output logic                     ras_empty,
  output logic                     ras_full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] FOUR = ADDRESS_WIDTH'(4);

  logic [ADDRESS_WIDTH-1:0] stack [RAS_DEPTH];
  logic [PW-1:0]            top;
  logic [PW-1:0]            push_slot;
  logic [CW-1:0]            count;
  logic [ADDRESS_WIDTH-1:0] cand;
  logic [ADDRESS_WIDTH-1:0] top_entry;
  logic [ADDRESS_WIDTH-1:0] jalr_sum;
  logic                     pop;
  logic                     misaligned;
  logic                     advance;
  logic                     commit;

  assign inc_PC    = PC + FOUR;
  assign ras_empty = (count == '0);
  assign ras_full  = (count == FULL);
  assign top_entry = stack[top];
  assign jalr_sum  = rs1 + ImmOp;
  assign pop       = (PCsrc == 2'b11) && !ras_empty;

  always_comb begin
    cand = inc_PC;
    unique case (PCsrc)
      2'b01:   cand = PC + (ImmOp << IMM_SHIFT);
      2'b10:   cand = {jalr_sum[ADDRESS_WIDTH-1:1], 1'b0};
      2'b11:   cand = ras_empty ? inc_PC : top_entry;
      default: cand = inc_PC;
    endcase
  end

  assign misaligned = (cand[1:0] != 2'b00);
  assign advance    = !stall && !trap;
  assign commit     = advance && !misaligned;
  // A tail call reuses the popped slot instead of stacking above it.
  assign push_slot  = pop ? top : top + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC    <= RESET_VECTOR;
      trap  <= 1'b0;
      top   <= '0;
      count <= '0;
    end else if (advance) begin
      if (misaligned) begin
        trap <= 1'b1;
      end else begin
        PC <= cand;
        if (push && !pop) begin
          top <= top + PW'(1);
          if (!ras_full) count <= count + CW'(1);
        end else if (pop && !push) begin
          top   <= top - PW'(1);
          count <= count - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit && push && !rst) stack[push_slot] <= inc_PC;
  end

endmodule
